// File: rtl/l2_burst_engine.sv
// ============================================================================
// Module      : l2_burst_engine
// Description : JTAG-to-L2 burst engine; auto-incrementing word bursts to a
//               word-interleaved multi-bank L2 with a credit-limited read FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_burst_engine #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NB_BANKS    = 4,
    parameter int MAX_BURST   = 256,
    parameter int RDATA_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
    input  logic [$clog2(MAX_BURST)-1:0]  cmd_len_i,
    input  logic                          wdata_valid_i,
    output logic                          wdata_ready_o,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic                          rdata_valid_o,
    input  logic                          rdata_ready_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [NB_BANKS-1:0]           mem_req_o,
    input  logic [NB_BANKS-1:0]           mem_gnt_i,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       mem_be_o,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_BYTES);
    localparam int c_BANK_W = $clog2(NB_BANKS);
    localparam int c_LEN_W  = $clog2(MAX_BURST);
    localparam int c_PTR_W  = (RDATA_DEPTH > 1) ? $clog2(RDATA_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(RDATA_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [c_LEN_W:0]        r_remaining;
    logic                    r_outstanding;
    logic                    r_done;
    logic                    r_err;

    logic [DATA_WIDTH-1:0]   r_fifo [RDATA_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    logic [NB_BANKS-1:0]     w_bank_onehot;
    logic                    w_misaligned;
    logic [c_CNT_W:0]        w_inflight;
    logic                    w_credit;
    logic                    w_req;
    logic                    w_gnt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last;

    // Word-interleaved banks: the low word-address bits pick the bank.
    generate
        if (NB_BANKS > 1) begin : g_multi_bank
            logic [c_BANK_W-1:0] w_bank;
            assign w_bank        = r_addr[c_OFF_W +: c_BANK_W];
            assign w_bank_onehot = NB_BANKS'(1) << w_bank;
        end else begin : g_single_bank
            assign w_bank_onehot = 1'b1;
        end
    endgenerate

    assign w_misaligned = (cmd_addr_i & ADDR_WIDTH'(c_BYTES - 1)) != '0;

    // Credit covers words already queued plus the one whose rvalid is in flight.
    assign w_inflight = {1'b0, r_count} + (c_CNT_W + 1)'(r_outstanding);
    assign w_credit   = w_inflight < (c_CNT_W + 1)'(RDATA_DEPTH);

    assign w_req = ((r_state == S_WRITE) && wdata_valid_i) ||
                   ((r_state == S_READ) && w_credit);
    assign w_gnt  = |(mem_req_o & mem_gnt_i);
    assign w_last = (r_remaining == (c_LEN_W + 1)'(1));

    assign mem_req_o     = w_req ? w_bank_onehot : '0;
    assign mem_we_o      = (r_state == S_WRITE);
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = (r_state == S_WRITE) ? wdata_i : '0;
    assign mem_be_o      = {c_BYTES{w_req}};
    assign wdata_ready_o = (r_state == S_WRITE) && w_gnt;

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE) || r_done;
    assign done_o      = r_done;
    assign err_o       = r_err;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_outstanding <= (r_state == S_READ) && w_gnt;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr      <= cmd_addr_i;
                            r_remaining <= {1'b0, cmd_len_i} + (c_LEN_W + 1)'(1);
                            r_state     <= cmd_we_i ? S_WRITE : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_gnt) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(c_BYTES);
                        r_remaining <= r_remaining - (c_LEN_W + 1)'(1);
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    if (w_gnt) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(c_BYTES);
                        r_remaining <= r_remaining - (c_LEN_W + 1)'(1);
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_push) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Only rvalids that answer a grant of the current burst are accepted,
    // so a response still in flight across a reset is dropped.
    assign w_push        = mem_rvalid_i && r_outstanding;
    assign rdata_valid_o = (r_count != '0);
    assign w_pop         = rdata_valid_o && rdata_ready_i;
    assign rdata_o       = rdata_valid_o ? r_fifo[r_rd_ptr] : '0;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(RDATA_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l2_burst_engine.sv
// ============================================================================
// Module      : tb_l2_burst_engine
// Description : Directed bench for l2_burst_engine with an L2 model and a
//               read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_burst_engine;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] wdata_i;
    logic        rdata_valid_o, rdata_ready_i;
    logic [31:0] rdata_o;
    logic [3:0]  mem_req_o, mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o, done_o, err_o;

    l2_burst_engine dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  req;
        logic        we;
        int          cyc;
    } acc_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          done_cnt = 0;
    int          pop_cnt  = 0;
    int          first_valid_cyc = -1;
    acc_t        log_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wbuf [16];
    logic [3:0]  gnt_mask = 4'hF;
    bit   [31:0] mem_model [bit [31:0]];
    logic        nxt_rvalid = 1'b0;
    logic [31:0] nxt_rdata  = '0;

    assign mem_gnt_i = gnt_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cycle <= cycle + 1;

    // L2 model, access log and scoreboard, all sampled mid-cycle.
    always @(negedge clk_i) begin
        acc_t a;
        logic [31:0] exp_word;
        nxt_rvalid = 1'b0;
        if (rst_n) begin
            if (|(mem_req_o & mem_gnt_i)) begin
                a.addr = mem_addr_o; a.wdata = mem_wdata_o; a.req = mem_req_o;
                a.we = mem_we_o; a.cyc = cycle;
                log_q.push_back(a);
                check("be_all_ones", mem_be_o, 4'hF);
                if (mem_we_o) begin
                    mem_model[mem_addr_o] = mem_wdata_o;
                end else begin
                    nxt_rvalid = 1'b1;
                    nxt_rdata  = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
                end
            end
            if (done_o) begin
                done_cnt++;
                check("busy_at_done", busy_o, 1);
            end
            if (rdata_valid_o && first_valid_cyc < 0) first_valid_cyc = cycle;
            if (rdata_valid_o && rdata_ready_i) begin
                check("sb_expect_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("sb_rdata", rdata_o, exp_word);
                end
                pop_cnt++;
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        mem_rvalid_i = nxt_rvalid;
        mem_rdata_i  = nxt_rdata;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_mem_req"}, mem_req_o, 0);
        check({tag, "_mem_we"}, mem_we_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
        check({tag, "_mem_be"}, mem_be_o, 0);
        check({tag, "_wdata_ready"}, wdata_ready_o, 0);
        check({tag, "_rdata_valid"}, rdata_valid_o, 0);
        check({tag, "_rdata"}, rdata_o, 0);
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input int len);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = 8'(len);
        @(negedge clk_i);
        check("cmd_ready_idle", cmd_ready_o, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) begin seen = 1; break; end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            @(negedge clk_i);
            check({tag, "_done_single"}, done_o, 0);
            check({tag, "_busy_after"}, busy_o, 0);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input int n, input int stall_n);
        int k = 0;
        int stall = 0;
        int cyc = 0;
        log_q.delete();
        send_cmd(1'b1, addr, n - 1);
        wdata_valid_i = 1'b1; wdata_i = wbuf[0];
        while (k < n && cyc < 200) begin
            gnt_mask = (stall < stall_n) ? 4'b1011 : 4'hF;
            @(negedge clk_i);
            if (mem_req_o == 4'b0100 && !mem_gnt_i[2]) begin
                stall++;
                check("stall_wdata_ready", wdata_ready_o, 0);
                check("stall_addr", mem_addr_o, addr + 32'(4 * k));
                check("stall_wdata", mem_wdata_o, wbuf[k]);
            end
            if (wdata_ready_o) k++;
            @(posedge clk_i); #1;
            wdata_valid_i = (k < n);
            wdata_i = (k < n) ? wbuf[k] : 32'h0;
            cyc++;
        end
        gnt_mask = 4'hF; wdata_valid_i = 1'b0;
        check("wr_words_accepted", k, n);
        check("wr_stall_cycles", stall, stall_n);
        wait_done("wr", 20);
    endtask

    task automatic run_read(input logic [31:0] addr, input int n);
        send_cmd(1'b0, addr, n - 1);
        wait_done("rd", 300);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk_i);
        check("rd_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 1'b0; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_len_i = 0;
        wdata_valid_i = 0; wdata_i = 0; rdata_ready_i = 1'b1;
        mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (3) @(negedge clk_i);
        check_reset_vals("reset");
        @(posedge clk_i); #1 rst_n = 1'b1;

        // Basic write/read burst
        wbuf[0] = 32'hABBAABBA; wbuf[1] = 32'h1; wbuf[2] = 32'h2; wbuf[3] = 32'h3;
        run_write(32'h0, 4, 0);
        check("w1_grants", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("w1_req_walk", log_q[i].req, 4'b0001 << i);
            check("w1_addr", log_q[i].addr, 32'(4 * i));
            check("w1_wdata", log_q[i].wdata, wbuf[i]);
            check("w1_we", log_q[i].we, 1);
        end
        if (log_q.size() == 4) check("w1_throughput", log_q[3].cyc - log_q[0].cyc, 3);

        log_q.delete(); first_valid_cyc = -1; p0 = pop_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(wbuf[i]);
        run_read(32'h0, 4);
        check("r1_grants", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check("r1_req_walk", log_q[i].req, 4'b0001 << i);
        if (log_q.size() == 4) begin
            check("r1_latency", first_valid_cyc - log_q[0].cyc, 2);
            check("r1_throughput", log_q[3].cyc - log_q[0].cyc, 3);
        end
        check("r1_pops", pop_cnt - p0, 4);

        // Read backpressure with a 16-word burst
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000 + 32'(i);
        run_write(32'h100, 16, 0);
        rdata_ready_i = 1'b0; log_q.delete(); p0 = pop_cnt;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + 32'(i));
        send_cmd(1'b0, 32'h100, 15);
        repeat (20) @(negedge clk_i);
        check("bp_grants", log_q.size(), 4);
        check("bp_req_stopped", mem_req_o, 0);
        check("bp_rdata_valid", rdata_valid_o, 1);
        @(posedge clk_i); #1 rdata_ready_i = 1'b1;
        wait_done("bp", 200);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk_i);
        check("bp_drained", exp_q.size(), 0);
        check("bp_pops", pop_cnt - p0, 16);

        // Grant stall on bank 2
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
        run_write(32'h200, 4, 5);
        check("st_grants", log_q.size(), 4);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE0000 + 32'(i));
        run_read(32'h200, 4);

        // Misaligned command
        log_q.delete();
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h2; cmd_len_i = 8'd3;
        @(negedge clk_i);
        check("mis_err_not_yet", err_o, 0);
        @(posedge clk_i); #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("mis_err_pulse", err_o, 1);
        check("mis_busy", busy_o, 0);
        check("mis_req", mem_req_o, 0);
        @(negedge clk_i);
        check("mis_err_single", err_o, 0);
        check("mis_busy_later", busy_o, 0);
        repeat (3) @(negedge clk_i);
        check("mis_no_access", log_q.size(), 0);
        check("mis_ready", cmd_ready_o, 1);

        // Address wrap
        wbuf[0] = 32'h5A5A0001; wbuf[1] = 32'h5A5A0002;
        run_write(32'hFFFF_FFFC, 2, 0);
        check("wrap_grants", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("wrap_addr0", log_q[0].addr, 32'hFFFF_FFFC);
            check("wrap_req0", log_q[0].req, 4'b1000);
            check("wrap_addr1", log_q[1].addr, 32'h0);
            check("wrap_req1", log_q[1].req, 4'b0001);
        end

        // Asynchronous reset mid-read, then a clean read
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h3000 + 32'(i);
        run_write(32'h300, 8, 0);
        rdata_ready_i = 1'b0; log_q.delete();
        send_cmd(1'b0, 32'h300, 7);
        for (int i = 0; i < 50 && log_q.size() < 3; i++) @(negedge clk_i);
        check("rst_three_grants", log_q.size(), 3);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("midrst_late_rvalid_ignored", rdata_valid_o, 0);
            check("midrst_idle", busy_o, 0);
        end
        rdata_ready_i = 1'b1; p0 = pop_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h3000 + 32'(i));
        run_read(32'h300, 8);
        check("post_rst_pops", pop_cnt - p0, 8);

        check("done_total", done_cnt, 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
